// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared operand-timing encodings and MD latencies
package hazard_ctrl_pkg;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam logic [1:0] TUSE_ID = 2'd0;
  localparam logic [1:0] TUSE_EX = 2'd1;
  localparam logic [1:0] TUSE_MEM = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  function automatic logic src_hz(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] wa_ex,
    input logic [1:0] tnew_ex,
    input logic [4:0] wa_mem,
    input logic [1:0] tnew_mem
  );
    return (r != 5'd0) && (tuse != TUSE_NONE) &&
           ((r == wa_ex && tnew_ex > tuse) || (r == wa_mem && tnew_mem > tuse));
  endfunction
endpackage

// File: rtl/hazard_ctrl_md_counter.sv
// md_counter: IDLE/BUSY down-counter tracking the multiply/divide unit
module md_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= BUSY;
        cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end
    end else begin
      // a start seen while busy is deliberately ignored
      cnt <= (cnt == CNT_W'(1)) ? '0 : cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state <= IDLE;
    end
  end
  assign busy = (state == BUSY);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew stall decision plus MD-busy interlock
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic [1:0] tuse_rs_ID,
  input  logic [1:0] tuse_rt_ID,
  input  logic       md_use_ID,
  input  logic [4:0] wa_EX,
  input  logic [1:0] tnew_EX,
  input  logic [4:0] wa_MEM,
  input  logic [1:0] tnew_MEM,
  input  logic       md_start_EX,
  input  logic       md_div_EX,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       clr_id_ex,
  output logic       md_busy
);
  logic busy, hz_rs, hz_rt, hz_md, stall;
  md_counter #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_md (
    .clk(clk),
    .reset(reset),
    .start(md_start_EX),
    .is_div(md_div_EX),
    .busy(busy)
  );
  always_comb begin
    hz_rs = src_hz(rs_ID, tuse_rs_ID, wa_EX, tnew_EX, wa_MEM, tnew_MEM);
    hz_rt = src_hz(rt_ID, tuse_rt_ID, wa_EX, tnew_EX, wa_MEM, tnew_MEM);
    hz_md = md_use_ID & (busy | md_start_EX);
    stall = ~reset & (hz_rs | hz_rt | hz_md);
  end
  assign stall_pc = stall;
  assign stall_if_id = stall;
  assign clr_id_ex = stall;
  assign md_busy = ~reset & busy;
endmodule
